// File: rtl/alu_exec_if.sv
// Handshake and operand bundle between an issuing stage and alu_exec_unit.
// The master side offers operations and consumes results; the slave side is the execution unit.
interface alu_exec_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic            opb5;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            funct7b0;
    logic [1:0]      ALUOp;
    logic [XLEN-1:0] srcA;
    logic [XLEN-1:0] srcB;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic [3:0]      ALUControl;
    logic            busy;

    modport master (
        output in_valid, opb5, funct3, funct7b5, funct7b0, ALUOp, srcA, srcB, flush, out_ready,
        input  in_ready, out_valid, result, zero, ALUControl, busy
    );

    modport slave (
        input  in_valid, opb5, funct3, funct7b5, funct7b0, ALUOp, srcA, srcB, flush, out_ready,
        output in_ready, out_valid, result, zero, ALUControl, busy
    );
endinterface

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle integer ops plus an iterative radix-2 shift-add multiplier,
// with a registered result held under valid/ready backpressure.
module alu_exec_unit #(
    parameter int unsigned XLEN     = 32,
    parameter bit          ENABLE_M = 1'b1
) (
    input logic       clk,
    input logic       reset,
    alu_exec_if.slave io
);
    localparam int unsigned ShW = $clog2(XLEN);

    localparam logic [3:0] OpAdd  = 4'b0000;
    localparam logic [3:0] OpSub  = 4'b0001;
    localparam logic [3:0] OpAnd  = 4'b0010;
    localparam logic [3:0] OpOr   = 4'b0011;
    localparam logic [3:0] OpXor  = 4'b0100;
    localparam logic [3:0] OpSlt  = 4'b0101;
    localparam logic [3:0] OpSltu = 4'b0110;
    localparam logic [3:0] OpSll  = 4'b0111;
    localparam logic [3:0] OpSrl  = 4'b1000;
    localparam logic [3:0] OpSra  = 4'b1001;
    localparam logic [3:0] OpMul  = 4'b1010;

    typedef enum logic {StIdle, StMulBusy} state_e;

    state_e          state_q, state_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic [3:0]      ctrl_q, ctrl_d;
    logic [ShW-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;

    logic            in_ready;
    logic            accept;
    logic [3:0]      dec_ctrl;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] acc_next;
    logic [ShW-1:0]  shamt;

    always_comb begin
        dec_ctrl = OpAdd;
        unique case (io.ALUOp)
            2'b01: dec_ctrl = OpSub;
            2'b10: begin
                unique case (io.funct3)
                    3'b000: dec_ctrl = (io.opb5 && io.funct7b5) ? OpSub : OpAdd;
                    3'b001: dec_ctrl = OpSll;
                    3'b010: dec_ctrl = OpSlt;
                    3'b011: dec_ctrl = OpSltu;
                    3'b100: dec_ctrl = OpXor;
                    3'b101: dec_ctrl = io.funct7b5 ? OpSra : OpSrl;
                    3'b110: dec_ctrl = OpOr;
                    default: dec_ctrl = OpAnd;
                endcase
                // M-extension multiply overrides the base decode of funct3 000 only.
                if (ENABLE_M && io.opb5 && io.funct7b0 && (io.funct3 == 3'b000)) begin
                    dec_ctrl = OpMul;
                end
            end
            default: dec_ctrl = OpAdd;
        endcase
    end

    assign shamt = io.srcB[ShW-1:0];

    always_comb begin
        alu_res = '0;
        unique case (dec_ctrl)
            OpAdd:  alu_res = io.srcA + io.srcB;
            OpSub:  alu_res = io.srcA - io.srcB;
            OpAnd:  alu_res = io.srcA & io.srcB;
            OpOr:   alu_res = io.srcA | io.srcB;
            OpXor:  alu_res = io.srcA ^ io.srcB;
            OpSlt:  alu_res = {{(XLEN-1){1'b0}}, ($signed(io.srcA) < $signed(io.srcB))};
            OpSltu: alu_res = {{(XLEN-1){1'b0}}, (io.srcA < io.srcB)};
            OpSll:  alu_res = io.srcA << shamt;
            OpSrl:  alu_res = io.srcA >> shamt;
            OpSra:  alu_res = $unsigned($signed(io.srcA) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign accept   = io.in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            ctrl_q      <= OpAdd;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            ctrl_q      <= ctrl_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        ctrl_d      = ctrl_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        if (io.flush) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
            cnt_d       = '0;
        end else begin
            if (out_valid_q && io.out_ready) begin
                out_valid_d = 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        ctrl_d = dec_ctrl;
                        if (dec_ctrl == OpMul) begin
                            state_d  = StMulBusy;
                            cnt_d    = '0;
                            acc_d    = '0;
                            mcand_d  = io.srcA;
                            mplier_d = io.srcB;
                        end else begin
                            result_d    = alu_res;
                            zero_d      = (alu_res == '0);
                            out_valid_d = 1'b1;
                        end
                    end
                end
                default: begin
                    acc_d    = acc_next;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == ShW'(XLEN - 1)) begin
                        state_d     = StIdle;
                        cnt_d       = '0;
                        result_d    = acc_next;
                        zero_d      = (acc_next == '0);
                        out_valid_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        in_ready      = (state_q == StIdle) && (!out_valid_q || io.out_ready) && !io.flush;
        io.in_ready   = in_ready;
        io.out_valid  = out_valid_q;
        io.result     = result_q;
        io.zero       = zero_q;
        io.ALUControl = ctrl_q;
        io.busy       = (state_q == StMulBusy);
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: vector table through a scoreboard, plus
// hand-written multiply timing, backpressure, flush and reset sequences.
module tb_alu_exec_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_exec_if #(.XLEN(32)) bus ();
    alu_exec_if #(.XLEN(32)) bus0 ();

    // Second unit without the multiplier sees identical stimulus.
    assign bus0.in_valid  = bus.in_valid;
    assign bus0.opb5      = bus.opb5;
    assign bus0.funct3    = bus.funct3;
    assign bus0.funct7b5  = bus.funct7b5;
    assign bus0.funct7b0  = bus.funct7b0;
    assign bus0.ALUOp     = bus.ALUOp;
    assign bus0.srcA      = bus.srcA;
    assign bus0.srcB      = bus.srcB;
    assign bus0.flush     = bus.flush;
    assign bus0.out_ready = bus.out_ready;

    alu_exec_unit #(.XLEN(32), .ENABLE_M(1'b1)) dut (.clk(clk), .reset(reset), .io(bus));
    alu_exec_unit #(.XLEN(32), .ENABLE_M(1'b0)) dut0 (.clk(clk), .reset(reset), .io(bus0));

    typedef struct {
        logic        opb5;
        logic [2:0]  f3;
        logic        f7b5;
        logic        f7b0;
        logic [1:0]  aluop;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  ctrl;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  ctrl;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endfunction

    function automatic vec_t mk(logic opb5, logic [2:0] f3, logic f7b5, logic f7b0,
                                logic [1:0] aluop, logic [31:0] a, logic [31:0] b,
                                logic [31:0] res, logic [3:0] ctrl);
        vec_t v;
        v.opb5 = opb5; v.f3 = f3; v.f7b5 = f7b5; v.f7b0 = f7b0; v.aluop = aluop;
        v.a = a; v.b = b; v.res = res; v.ctrl = ctrl;
        return v;
    endfunction

    task automatic push_exp(input logic [31:0] res, input logic [3:0] ctrl);
        exp_t e;
        e.res  = res;
        e.ctrl = ctrl;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at a drive point (#1 after posedge); returns at the drive point after acceptance.
    task automatic send(input vec_t v, input bit expect_out);
        int n;
        bus.opb5 = v.opb5; bus.funct3 = v.f3; bus.funct7b5 = v.f7b5; bus.funct7b0 = v.f7b0;
        bus.ALUOp = v.aluop; bus.srcA = v.a; bus.srcB = v.b; bus.in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            n_total++;
            $display("FAIL accept_timeout: in_ready 0 after %0d cycles, expected 1", n);
        end else if (expect_out) begin
            push_exp(v.res, v.ctrl);
        end
        step();
        bus.in_valid = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && bus.out_valid && bus.out_ready && !bus.flush) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_output: got result 0x%0h, expected none", bus.result);
            end else begin
                e = sb.pop_front();
                check("sb_result", bus.result, e.res);
                check("sb_ctrl", bus.ALUControl, e.ctrl);
                check("sb_zero", bus.zero, e.res == 32'h0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1);
    end

    vec_t tbl[17];
    vec_t v032, vmul, vbp1, vbp2, vmul5, vsltu;
    int   bad;

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.opb5 = 1'b0; bus.funct3 = 3'b0; bus.funct7b5 = 1'b0;
        bus.funct7b0 = 1'b0; bus.ALUOp = 2'b0; bus.srcA = '0; bus.srcB = '0;
        bus.flush = 1'b0; bus.out_ready = 1'b1;

        tbl[0]  = mk(0, 3'b000, 0, 0, 2'b00, 32'd5, 32'd7, 32'd12, 4'h0);
        tbl[1]  = mk(0, 3'b000, 0, 0, 2'b01, 32'd5, 32'd5, 32'd0, 4'h1);
        tbl[2]  = mk(0, 3'b000, 0, 0, 2'b11, 32'd1, 32'd2, 32'd3, 4'h0);
        tbl[3]  = mk(1, 3'b000, 1, 0, 2'b10, 32'd7, 32'd9, 32'hFFFFFFFE, 4'h1);
        tbl[4]  = mk(0, 3'b000, 1, 0, 2'b10, 32'd7, 32'd9, 32'd16, 4'h0);
        tbl[5]  = mk(1, 3'b001, 0, 0, 2'b10, 32'd1, 32'd36, 32'h10, 4'h7);
        tbl[6]  = mk(1, 3'b010, 0, 0, 2'b10, 32'hFFFFFFFF, 32'd1, 32'd1, 4'h5);
        tbl[7]  = mk(1, 3'b011, 0, 0, 2'b10, 32'hFFFFFFFF, 32'd1, 32'd0, 4'h6);
        tbl[8]  = mk(1, 3'b100, 0, 0, 2'b10, 32'hF0F0F0F0, 32'hFFFF0000, 32'h0F0FF0F0, 4'h4);
        tbl[9]  = mk(1, 3'b000, 0, 1, 2'b10, 32'd6, 32'd7, 32'd42, 4'hA);
        tbl[10] = mk(0, 3'b101, 1, 0, 2'b10, 32'h80000000, 32'd4, 32'hF8000000, 4'h9);
        tbl[11] = mk(0, 3'b101, 0, 0, 2'b10, 32'h80000000, 32'd4, 32'h08000000, 4'h8);
        tbl[12] = mk(1, 3'b110, 0, 0, 2'b10, 32'h0000FF00, 32'h00FF0000, 32'h00FFFF00, 4'h3);
        tbl[13] = mk(1, 3'b111, 0, 0, 2'b10, 32'h0F0F0F0F, 32'hFF00FF00, 32'h0F000F00, 4'h2);
        tbl[14] = mk(1, 3'b100, 0, 1, 2'b10, 32'd3, 32'd5, 32'd6, 4'h4);
        tbl[15] = mk(0, 3'b000, 0, 1, 2'b10, 32'd2, 32'd3, 32'd5, 4'h0);
        tbl[16] = mk(1, 3'b101, 1, 0, 2'b10, 32'hFFFFFF00, 32'h104, 32'hFFFFFFF0, 4'h9);

        v032  = mk(1, 3'b000, 1, 0, 2'b10, 32'd7, 32'd9, 32'hFFFFFFFE, 4'h1);
        vmul  = mk(1, 3'b000, 0, 1, 2'b10, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD, 4'hA);
        vbp1  = mk(0, 3'b000, 0, 0, 2'b00, 32'd10, 32'd20, 32'd30, 4'h0);
        vbp2  = mk(0, 3'b000, 0, 0, 2'b00, 32'd1, 32'd1, 32'd2, 4'h0);
        vmul5 = mk(1, 3'b000, 0, 1, 2'b10, 32'd5, 32'd5, 32'd25, 4'hA);
        vsltu = mk(1, 3'b011, 0, 0, 2'b10, 32'd1, 32'hFFFFFFFF, 32'd1, 4'h6);

        // Reset state
        #12;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_result", bus.result, 0);
        check("rst_zero", bus.zero, 0);
        check("rst_ctrl", bus.ALUControl, 0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", bus.in_ready, 1);
        step();

        foreach (tbl[i]) send(tbl[i], 1'b1);

        for (int k = 0; k < 100 && (bus.busy || bus.out_valid); k++) step();
        check("table_drained", {bus.busy, bus.out_valid}, 0);

        // Non-MUL latency 1
        send(v032, 1'b1);
        @(negedge clk);
        check("sub_latency", bus.out_valid, 1);
        step();

        // MUL timing, plus the same opcode on the unit without multiplier
        send(vmul, 1'b1);
        bad = 0;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (i == 1) begin
                check("nom_out_valid", bus0.out_valid, 1);
                check("nom_result", bus0.result, 32'd2);
                check("nom_ctrl", bus0.ALUControl, 4'h0);
            end
            if (!bus.busy || bus.in_ready || bus.out_valid) bad++;
            step();
        end
        check("mul_busy_window", bad, 0);
        @(negedge clk);
        check("mul_latency", bus.out_valid, 1);
        check("mul_busy_done", bus.busy, 0);
        step();

        // Backpressure: hold the first result for 3 cycles with a second op waiting
        bus.out_ready = 1'b0;
        send(vbp1, 1'b1);
        bus.opb5 = vbp2.opb5; bus.funct3 = vbp2.f3; bus.funct7b5 = vbp2.f7b5;
        bus.funct7b0 = vbp2.f7b0; bus.ALUOp = vbp2.aluop; bus.srcA = vbp2.a; bus.srcB = vbp2.b;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_valid", bus.out_valid, 1);
            check("bp_hold_result", bus.result, 32'd30);
            check("bp_in_ready", bus.in_ready, 0);
            step();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", bus.in_ready, 1);
        push_exp(vbp2.res, vbp2.ctrl);
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("bp_second_valid", bus.out_valid, 1);
        step();

        // Flush at iteration 10 of a multiply
        send(vmul5, 1'b0);
        repeat (10) step();
        bus.flush = 1'b1;
        @(negedge clk);
        check("flush_blocks_ready", bus.in_ready, 0);
        step();
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush_out_valid", bus.out_valid, 0);
        check("flush_busy", bus.busy, 0);
        check("flush_in_ready", bus.in_ready, 1);
        step();
        send(vsltu, 1'b1);
        @(negedge clk);
        check("sltu_after_flush_lat", bus.out_valid, 1);
        step();

        // Reset asserted mid-multiply
        send(vmul5, 1'b0);
        repeat (5) step();
        reset = 1'b1;
        #1;
        check("midreset_busy", bus.busy, 0);
        check("midreset_out_valid", bus.out_valid, 0);
        check("midreset_result", bus.result, 0);
        check("midreset_ctrl", bus.ALUControl, 0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("midreset_in_ready", bus.in_ready, 1);
        check("midreset_busy_after", bus.busy, 0);
        step();
        send(vsltu, 1'b1);
        @(negedge clk);
        check("sltu_after_reset_lat", bus.out_valid, 1);
        step();

        repeat (3) step();
        check("scoreboard_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
